smi_read_fifo: RTL and testbench

//   Buffer between the sample producer (counter/ADC front end) and the SMI
//   pin driver. Stores producer words and presents the head word on out_data
//   for the pin driver to put on SMI_SD[15:0]. Advances one word per completed
//   Pi read strobe (SMI_SOE) while the SMI address decode is selected.

---
 rtl/smi_read_fifo.sv | 147 ++++++++++++++
 tb/tb_smi_read_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/smi_read_fifo.sv
// smi_read_fifo: producer-to-SMI read buffer. A head register presents the
// oldest word to the pin driver; the remaining words live in a block RAM with
// a registered read port. The head advances once per completed, selected
// SMI_SOE read strobe.
module smi_read_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  smi_soe_n,
    input  logic                  smi_sel,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underrun,
    input  logic                  clr_flags
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {IDLE, STROBE} state_t;

    logic [SYNC_STAGES-1:0] soe_sync, sel_sync, live_sr;
    logic                   soe_s, sel_s, live;
    state_t                 state, state_nxt;
    logic                   sel_q, soe_hi, strobe_start, pop_req;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DATA_W-1:0]      ram_q, byp_d, rd_q;
    logic                   byp_q, ready_en;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr, rd_addr;
    logic [DEPTH_LOG2:0]    mem_cnt;
    logic                   push, pop, mem_has, head_load, mem_we, mem_pop;

    assign soe_s = soe_sync[SYNC_STAGES-1];
    assign sel_s = sel_sync[SYNC_STAGES-1];
    // live goes high once the chains hold real pin samples rather than reset fill,
    // so a strobe already low at reset release is never mistaken for a new one.
    assign live  = live_sr[SYNC_STAGES-1];

    // Synchronisers for the asynchronous SMI pins, plus the chain-fill tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soe_sync <= '1;
            sel_sync <= '0;
            live_sr  <= '0;
        end else begin
            soe_sync <= {soe_sync[SYNC_STAGES-2:0], smi_soe_n};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], smi_sel};
            live_sr  <= {live_sr[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Strobe FSM state, latched select and last genuine synced SOE level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= 1'b0;
            soe_hi <= 1'b0;
        end else begin
            state <= state_nxt;
            if (strobe_start) sel_q <= sel_s;
            if (live) soe_hi <= soe_s;
        end
    end

    // Falling edge opens a strobe; rising edge closes it and pops if selected.
    always_comb begin
        state_nxt    = state;
        strobe_start = 1'b0;
        pop_req      = 1'b0;
        case (state)
            IDLE: if (live && soe_hi && !soe_s) begin
                state_nxt    = STROBE;
                strobe_start = 1'b1;
            end
            STROBE: if (soe_s) begin
                state_nxt = IDLE;
                pop_req   = sel_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = ready_en && (level != FULL);
    assign push      = in_valid && in_ready;
    assign pop       = pop_req && out_valid;
    assign mem_cnt   = level - {{DEPTH_LOG2{1'b0}}, out_valid};
    assign mem_has   = (mem_cnt != '0);
    // A push goes straight into the head when the head is (or is becoming) empty.
    assign head_load = push && (!out_valid || (pop && !mem_has));
    assign mem_we    = push && !head_load;
    assign mem_pop   = pop && mem_has;
    assign rd_addr   = mem_pop ? rd_ptr + 1'b1 : rd_ptr;
    // The RAM read is not write-through, so a word written to the address
    // being read this cycle is forwarded from a side register instead.
    assign rd_q      = byp_q ? byp_d : ram_q;

    // Block RAM: synchronous write, registered read of the next RAM head.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= in_data;
        ram_q <= mem[rd_addr];
    end

    // Pointers, level, head register, forwarding path and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            byp_q     <= 1'b0;
            byp_d     <= '0;
            ready_en  <= 1'b0;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            byp_q    <= mem_we && (wr_ptr == rd_addr);
            byp_d    <= in_data;
            if (mem_we)  wr_ptr <= wr_ptr + 1'b1;
            if (mem_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (head_load) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (mem_pop) begin
                out_data  <= rd_q;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            overflow <= (in_valid && !in_ready) || (overflow && !clr_flags);
            underrun <= (pop_req && !out_valid) || (underrun && !clr_flags);
        end
    end
endmodule

// File: tb/tb_smi_read_fifo.sv
// Testbench for smi_read_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_smi_read_fifo;
    localparam int DW = 16;
    localparam int DL = 8;
    localparam int SS = 2;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          smi_soe_n = 1'b1;
    logic          smi_sel = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [DL:0]   level;
    logic          overflow, underrun;
    logic          clr_flags = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    smi_read_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .smi_soe_n(smi_soe_n), .smi_sel(smi_sel),
        .out_data(out_data), .out_valid(out_valid), .level(level),
        .overflow(overflow), .underrun(underrun), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    // Reference model: words held as a queue (head at index 0), the pins seen
    // through a SYNC_STAGES-edge delay line, a strobe = low run of the delayed pin.
    int      q[$];
    bit      h_soe[$], h_sel[$];
    bit      m_strobe, m_selq, m_hi, m_rdy, m_ov, m_un;
    bit      s_soe, s_sel, m_popreq, m_ready, ev_ov, ev_un;
    int      m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); h_soe.delete(); h_sel.delete();
            m_strobe = 0; m_selq = 0; m_hi = 0; m_rdy = 0;
            m_ov = 0; m_un = 0; m_out = 0;
        end else begin
            m_popreq = 0;
            h_soe.push_back(smi_soe_n);
            h_sel.push_back(smi_sel);
            if (h_soe.size() > SS) begin
                s_soe = h_soe.pop_front();
                s_sel = h_sel.pop_front();
                if (!m_strobe && m_hi && !s_soe) begin
                    m_strobe = 1; m_selq = s_sel;
                end else if (m_strobe && s_soe) begin
                    m_strobe = 0; m_popreq = m_selq;
                end
                m_hi = s_soe;
            end
            m_ready = m_rdy && (q.size() < DEPTH);
            ev_ov = in_valid && !m_ready;
            ev_un = m_popreq && (q.size() == 0);
            if (m_popreq && q.size() > 0) void'(q.pop_front());
            if (in_valid && m_ready) q.push_back(int'(in_data));
            if (q.size() > 0) m_out = q[0];
            m_ov = ev_ov || (m_ov && !clr_flags);
            m_un = ev_un || (m_un && !clr_flags);
            m_rdy = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_data", 32'(out_data), 32'(m_out));
        chk("in_ready", 32'(in_ready), 32'(m_rdy && q.size() < DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underrun", 32'(underrun), 32'(m_un));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic strobe(input bit sel, input int lo, input int hi);
        smi_sel = sel; smi_soe_n = 1'b0;
        cyc(lo);
        smi_soe_n = 1'b1;
        cyc(hi);
    endtask

    int rnd_cycles;

    initial begin
        // Reset state
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Four pushes, no strobes
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        chk("t1_level", 32'(level), 32'd4);
        chk("t1_out_data", 32'(out_data), 32'h0001);
        chk("t1_out_valid", 32'(out_valid), 32'd1);

        // Four selected strobes step through the words
        strobe(1'b1, 8, 8); chk("t2_w2", 32'(out_data), 32'h0002);
        strobe(1'b1, 8, 8); chk("t2_w3", 32'(out_data), 32'h0003);
        strobe(1'b1, 8, 8); chk("t2_w4", 32'(out_data), 32'h0004);
        strobe(1'b1, 8, 8);
        chk("t2_empty", 32'(out_valid), 32'd0);
        chk("t2_level", 32'(level), 32'd0);

        // Unselected strobes never pop
        push_word(16'hA5A5);
        for (int i = 0; i < 3; i++) strobe(1'b0, 8, 8);
        chk("t3_level", 32'(level), 32'd1);
        chk("t3_underrun", 32'(underrun), 32'd0);
        chk("t3_out_data", 32'(out_data), 32'hA5A5);

        // Fill to full, overflow, clear, drain
        strobe(1'b1, 8, 8);
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = DW'(16'h1000 + i);
            cyc(1);
        end
        in_data = 16'hDEAD;
        cyc(1);
        in_valid = 1'b0;
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_level", 32'(level), 32'd256);
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
        chk("t4_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) strobe(1'b1, 4, 4);
        chk("t4_drained", 32'(out_valid), 32'd0);
        chk("t4_last", 32'(out_data), 32'h10FF);

        // Underrun on empty, then fall-through of a new word
        strobe(1'b1, 8, 8);
        chk("t5_underrun", 32'(underrun), 32'd1);
        chk("t5_hold", 32'(out_data), 32'h10FF);
        push_word(16'h1234);
        chk("t5_fwft", 32'(out_data), 32'h1234);
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;

        // Reset in the middle of a strobe
        for (int i = 0; i < 9; i++) push_word(DW'(16'h2000 + i));
        chk("t6_level10", 32'(level), 32'd10);
        smi_sel = 1'b1; smi_soe_n = 1'b0;
        cyc(6);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(4);
        push_word(16'h3000);
        push_word(16'h3001);
        cyc(4);
        smi_soe_n = 1'b1;
        cyc(10);
        chk("t6_no_pop", 32'(level), 32'd2);
        chk("t6_no_underrun", 32'(underrun), 32'd0);
        chk("t6_head", 32'(out_data), 32'h3000);

        // Randomized traffic: bursty producer against random strobes
        rnd_cycles = 4000;
        fork
            begin
                for (int c = 0; c < rnd_cycles; c++) begin
                    in_valid  = ($urandom_range(99) < ((c / 500) % 2 ? 70 : 15));
                    in_data   = DW'($urandom);
                    clr_flags = ($urandom_range(99) < 3);
                    cyc(1);
                end
                in_valid = 1'b0; clr_flags = 1'b0;
            end
            begin
                int spent;
                spent = 0;
                while (spent < rnd_cycles - 40) begin
                    int lo, hi;
                    lo = $urandom_range(10, 1);
                    hi = $urandom_range(10, 1);
                    smi_sel = ($urandom_range(3) != 0);
                    smi_soe_n = 1'b0;
                    for (int k = 0; k < lo; k++) begin
                        if ($urandom_range(3) == 0) smi_sel = ~smi_sel;
                        cyc(1);
                    end
                    smi_soe_n = 1'b1;
                    cyc(hi);
                    spent += lo + hi;
                end
            end
        join
        cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
